// File: rtl/pulse_line_scheduler.sv
// pulse_line_scheduler: round-robin owner of one DUT input line; drives a pulse of the
// winner's length, watches a response window for a hit, then holds a guard gap.
module pulse_line_scheduler #(
   parameter int N_REQ    = 4,
   parameter int LEN_W    = 8,
   parameter int RESP_WIN = 16,
   parameter int GAP      = 4,
   parameter int ID_W     = $clog2(N_REQ)
) (
   input  logic                   clck,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*LEN_W-1:0] req_len,
   output logic [N_REQ-1:0]       grant,
   output logic                   dut_in,
   input  logic                   dut_out,
   output logic                   done,
   output logic [ID_W-1:0]        done_id,
   output logic                   done_hit,
   output logic                   busy
);
   localparam int TW = $clog2(RESP_WIN + GAP + 1);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_GAP} state_t;

   state_t           state, state_n;
   logic [LEN_W-1:0] lens [N_REQ];
   logic [LEN_W-1:0] len_cnt, len_cnt_n, len_sel;
   logic [TW-1:0]    tmr, tmr_n;
   logic [ID_W-1:0]  owner, owner_n, ptr, ptr_n, win, idx;
   logic             hit, hit_n, found;
   logic [N_REQ-1:0] grant_n;
   logic             dut_in_n, done_n, done_hit_n;
   logic [ID_W-1:0]  done_id_n;

   for (genvar g = 0; g < N_REQ; g++) begin : g_len
      assign lens[g] = req_len[g*LEN_W +: LEN_W];
   end

   // first requesting index at or after the pointer, wrapping past N_REQ-1
   always_comb begin
      win   = ptr;
      found = 1'b0;
      idx   = ptr;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
         idx = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
      end
   end

   assign len_sel = lens[win];
   assign busy    = (state != S_IDLE);

   always_comb begin
      state_n    = state;
      len_cnt_n  = len_cnt;
      tmr_n      = tmr;
      owner_n    = owner;
      ptr_n      = ptr;
      hit_n      = hit;
      grant_n    = grant;
      dut_in_n   = dut_in;
      done_n     = 1'b0;
      done_id_n  = done_id;
      done_hit_n = done_hit;
      case (state)
         S_IDLE: if (|req) begin
            state_n   = S_DRIVE;
            owner_n   = win;
            grant_n   = N_REQ'(1) << win;
            dut_in_n  = 1'b1;
            len_cnt_n = (len_sel == '0) ? LEN_W'(1) : len_sel;
            hit_n     = 1'b0;
         end
         S_DRIVE: begin
            hit_n = hit | dut_out;
            if (len_cnt == LEN_W'(1)) begin
               state_n  = S_WAIT;
               dut_in_n = 1'b0;
               tmr_n    = TW'(RESP_WIN);
            end else
               len_cnt_n = len_cnt - 1'b1;
         end
         S_WAIT: begin
            hit_n = hit | dut_out;
            if (tmr == TW'(1)) begin
               state_n    = S_GAP;
               done_n     = 1'b1;
               done_id_n  = owner;
               done_hit_n = hit | dut_out;
               grant_n    = '0;
               ptr_n      = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
               tmr_n      = TW'(GAP);
            end else
               tmr_n = tmr - 1'b1;
         end
         default: begin
            state_n = (tmr == TW'(1)) ? S_IDLE : state;
            tmr_n   = (tmr == TW'(1)) ? tmr : tmr - 1'b1;
         end
      endcase
   end

   always_ff @(posedge clck or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         len_cnt  <= '0;
         tmr      <= '0;
         owner    <= '0;
         ptr      <= '0;
         hit      <= 1'b0;
         grant    <= '0;
         dut_in   <= 1'b0;
         done     <= 1'b0;
         done_id  <= '0;
         done_hit <= 1'b0;
      end else begin
         state    <= state_n;
         len_cnt  <= len_cnt_n;
         tmr      <= tmr_n;
         owner    <= owner_n;
         ptr      <= ptr_n;
         hit      <= hit_n;
         grant    <= grant_n;
         dut_in   <= dut_in_n;
         done     <= done_n;
         done_id  <= done_id_n;
         done_hit <= done_hit_n;
      end
   end
endmodule

// File: tb/tb_pulse_line_scheduler.sv
// tb_pulse_line_scheduler: directed stimulus, cycle-by-cycle comparison against a
// transaction-timeline model, plus literal expectations for each scenario.
module tb_pulse_line_scheduler;
   localparam int N = 4, LW = 8, RW = 16, GP = 4;

   logic            clck = 1'b0, rst = 1'b1, dut_out = 1'b0;
   logic [N-1:0]    req = '1;
   logic [N*LW-1:0] req_len = {N{8'd3}};
   logic [N-1:0]    grant;
   logic            dut_in, done, done_hit, busy;
   logic [1:0]      done_id;

   int checks = 0, errors = 0, cyc = 0, t0d = 0;

   bit act = 1'b0, mhit = 1'b0, mdhit = 1'b0;
   int mt0 = 0, mlen = 1, mown = 0, mptr = 0, mdid = 0;

   pulse_line_scheduler #(.N_REQ(N), .LEN_W(LW), .RESP_WIN(RW), .GAP(GP)) dut (
      .clck(clck), .rst(rst), .req(req), .req_len(req_len), .grant(grant),
      .dut_in(dut_in), .dut_out(dut_out), .done(done), .done_id(done_id),
      .done_hit(done_hit), .busy(busy)
   );

   always #5 clck = ~clck;

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at cycle %0d", name, a, e, cyc);
      end
   endtask

   // A transaction is a timeline from its cycle 0: L drive cycles, RW window cycles, GP gap cycles.
   always @(posedge clck) begin : model
      int r, w, l;
      if (rst) begin
         act   <= 1'b0;
         mptr  <= 0;
         mdid  <= 0;
         mdhit <= 1'b0;
      end else if (!act || cyc >= mt0 + mlen + RW + GP) begin
         if (req != '0) begin
            w = -1;
            for (int k = 0; k < N; k++)
               if (w < 0 && req[(mptr + k) % N]) w = (mptr + k) % N;
            l = int'(req_len[w*LW +: LW]);
            act  <= 1'b1;
            mt0  <= cyc + 1;
            mown <= w;
            mlen <= (l == 0) ? 1 : l;
            mhit <= 1'b0;
         end
      end else begin
         r = cyc - mt0;
         mhit <= mhit | dut_out;
         if (r == mlen + RW - 1) begin
            mdid  <= mown;
            mdhit <= mhit | dut_out;
            mptr  <= (mown + 1) % N;
         end
      end
      cyc <= cyc + 1;
   end

   always @(negedge clck) begin : mon
      int r;
      logic [N-1:0] eg;
      logic ed, edn, eb;
      eg = '0; ed = 1'b0; edn = 1'b0; eb = 1'b0;
      if (!rst && act && cyc >= mt0 && cyc < mt0 + mlen + RW + GP) begin
         r   = cyc - mt0;
         eg  = (r < mlen + RW) ? N'(1) << mown : '0;
         ed  = (r < mlen);
         edn = (r == mlen + RW);
         eb  = 1'b1;
      end
      chk("m_grant", 32'(grant), 32'(eg));
      chk("m_dut_in", 32'(dut_in), 32'(ed));
      chk("m_done", 32'(done), 32'(edn));
      chk("m_busy", 32'(busy), 32'(eb));
      chk("m_done_id", 32'(done_id), rst ? 0 : mdid);
      chk("m_done_hit", 32'(done_hit), rst ? 0 : 32'(mdhit));
   end

   task automatic go(input logic [N-1:0] v);
      @(posedge clck); #1;
      req = v;
      t0d = cyc + 1;
   endtask

   task automatic at_cycle(input int n);
      while (cyc < n) begin
         @(posedge clck); #1;
      end
   endtask

   task automatic wait_done(output int at, output int cnt);
      at = -1;
      cnt = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clck);
         if (dut_in) cnt++;
         if (done) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         checks++;
         errors++;
         $display("FAIL wait_done timed out at cycle %0d", cyc);
      end
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clck);
         if (!busy) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL wait_idle timed out at cycle %0d", cyc);
      end
   endtask

   task automatic pulse_rst();
      @(posedge clck); #1 rst = 1'b1;
      @(posedge clck); #1 rst = 1'b0;
   endtask

   initial begin
      int at, cnt, t;
      int ats[6], ids[6];
      int exp_ids[6] = '{0, 1, 3, 0, 1, 3};
      repeat (3) @(posedge clck);
      @(negedge clck);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_dut_in", 32'(dut_in), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      @(posedge clck); #1 rst = 1'b0;
      t0d = cyc + 1;
      repeat (2) @(negedge clck);
      chk("first_grant", 32'(grant), 32'b0001);
      req = '0;
      wait_idle();

      req_len[2*LW +: LW] = 8'd10;
      go(4'b0100);
      wait_done(at, cnt);
      chk("single_pulse_len", cnt, 10);
      chk("single_done_cycle", at - t0d, 26);
      chk("single_done_id", 32'(done_id), 2);
      chk("single_done_hit", 32'(done_hit), 0);
      t = -1;
      for (int i = 0; i < 60 && t < 0; i++) begin
         @(negedge clck);
         if (grant != '0) t = cyc;
      end
      chk("single_regrant_cycle", t - t0d, 31);
      chk("single_regrant", 32'(grant), 32'b0100);
      req = '0;
      wait_idle();

      pulse_rst();
      req_len = {N{8'd3}};
      go(4'b1011);
      for (int i = 0; i < 6; i++) begin
         wait_done(ats[i], cnt);
         ids[i] = int'(done_id);
      end
      req = '0;
      chk("rr_first_done", ats[0] - t0d, 19);
      for (int i = 0; i < 6; i++) chk("rr_order", ids[i], exp_ids[i]);
      for (int i = 1; i < 6; i++) chk("rr_spacing", ats[i] - ats[i-1], 24);
      wait_idle();

      req_len[0 +: LW] = 8'd5;
      go(4'b0001);
      at_cycle(t0d + 20);
      dut_out = 1'b1;
      @(posedge clck); #1 dut_out = 1'b0;
      wait_done(at, cnt);
      req = '0;
      chk("hit_done_cycle", at - t0d, 21);
      chk("hit_last_edge", 32'(done_hit), 1);
      wait_idle();
      go(4'b0001);
      at_cycle(t0d + 21);
      dut_out = 1'b1;
      @(posedge clck); #1 dut_out = 1'b0;
      wait_done(at, cnt);
      req = '0;
      chk("hit_too_late", 32'(done_hit), 0);
      wait_idle();

      req_len[0 +: LW] = 8'd0;
      go(4'b0001);
      wait_done(at, cnt);
      req = '0;
      chk("len0_pulse_len", cnt, 1);
      chk("len0_done_cycle", at - t0d, 17);
      wait_idle();
      req_len[3*LW +: LW] = 8'd255;
      go(4'b1000);
      wait_done(at, cnt);
      req = '0;
      chk("len255_pulse_len", cnt, 255);
      chk("len255_done_cycle", at - t0d, 271);
      chk("len255_done_id", 32'(done_id), 3);
      wait_idle();

      req_len[1*LW +: LW] = 8'd6;
      go(4'b0010);
      at_cycle(t0d + 2);
      req = '0;
      wait_done(at, cnt);
      chk("drop_done_cycle", at - t0d, 22);
      chk("drop_done_id", 32'(done_id), 1);
      wait_idle();

      go(4'b0100);
      at_cycle(t0d + 5);
      rst = 1'b1;
      req = '0;
      #1;
      chk("async_rst_dut_in", 32'(dut_in), 0);
      chk("async_rst_grant", 32'(grant), 0);
      chk("async_rst_busy", 32'(busy), 0);
      @(posedge clck); #1 rst = 1'b0;
      repeat (30) @(negedge clck);
      go(4'b1111);
      repeat (2) @(negedge clck);
      chk("ptr_after_rst", 32'(grant), 32'b0001);
      req = '0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
